// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: oversamples SCK/MOSI/CS in the i_clk domain, deserialises
// MSB-first frames and queues them in a show-ahead FIFO read by the core.
`timescale 1ns/1ps
module spi_slave_rx #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_spi_clk,
  input  logic              i_spi_mosi,
  input  logic              i_spi_cs,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty,
  output logic              o_full,
  output logic [ADDR_W:0]   o_count,
  output logic              o_ovf,
  input  logic              i_ovf_clr,
  output logic              o_frame_err,
  output logic              o_busy
);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PUSH} state_t;

  state_t              r_state, w_state_next;
  logic [2:0]          r_sck_sync, r_cs_sync;
  logic [1:0]          r_mosi_sync;
  logic [DATA_W-1:0]   r_shreg, w_shreg_next;
  logic [CNT_W-1:0]    r_bit_cnt, w_bit_cnt_next;
  logic                r_frame_err, w_frame_err_next;
  logic                w_push_req, w_push, w_pop, w_drop, w_full;
  logic                w_sck_rise, w_cs_rise, w_cs_s, w_mosi_s;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_ovf;

  // CS synchroniser resets to deasserted so no spurious frame start follows reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[1:0], i_spi_clk};
      r_cs_sync   <= {r_cs_sync[1:0], i_spi_cs};
      r_mosi_sync <= {r_mosi_sync[0], i_spi_mosi};
    end
  end

  assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];
  assign w_cs_s     = r_cs_sync[1];
  assign w_mosi_s   = r_mosi_sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shreg     <= w_shreg_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_shreg_next     = r_shreg;
    w_bit_cnt_next   = r_bit_cnt;
    w_frame_err_next = 1'b0;
    w_push_req       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_cs_s) begin
          w_state_next   = S_SHIFT;
          w_bit_cnt_next = '0;
        end
      end
      S_SHIFT: begin
        if (w_cs_rise) begin
          w_state_next     = S_IDLE;
          w_bit_cnt_next   = '0;
          w_frame_err_next = (r_bit_cnt != '0);
        end else if (w_sck_rise) begin
          w_shreg_next = {r_shreg[DATA_W-2:0], w_mosi_s};
          if (r_bit_cnt == CNT_W'(DATA_W-1)) begin
            w_state_next   = S_PUSH;
            w_bit_cnt_next = '0;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end
      S_PUSH: begin
        w_push_req     = 1'b1;
        w_bit_cnt_next = '0;
        w_state_next   = w_cs_s ? S_IDLE : S_SHIFT;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  assign w_full = (r_count == (ADDR_W+1)'(FIFO_DEPTH));
  assign w_pop  = i_rd & (r_count != '0);
  assign w_push = w_push_req & (~w_full | w_pop);
  assign w_drop = w_push_req & ~w_push;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shreg;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_drop)         r_ovf <= 1'b1;
      else if (i_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign o_empty     = (r_count == '0);
  assign o_full      = w_full;
  assign o_count     = r_count;
  assign o_data      = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_ovf       = r_ovf;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state == S_SHIFT) || (r_state == S_PUSH);
endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: drives SPI frames at SCK = clk/8 and
// compares popped words against a scoreboard queue of expected words.
`timescale 1ns/1ps
module tb_spi_slave_rx;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int AW     = 2;

  logic clk = 0, rst_n = 0, sck = 0, mosi = 0, cs = 1, rd = 0, ovf_clr = 0;
  logic [DATA_W-1:0] o_data;
  logic o_empty, o_full, o_ovf, o_frame_err, o_busy;
  logic [AW:0] o_count;

  int errors = 0, checks = 0;
  int fe_cnt = 0, busy_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];

  spi_slave_rx #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_spi_clk(sck), .i_spi_mosi(mosi), .i_spi_cs(cs),
    .i_rd(rd), .o_data(o_data), .o_empty(o_empty), .o_full(o_full), .o_count(o_count),
    .o_ovf(o_ovf), .i_ovf_clr(ovf_clr), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_frame_err) fe_cnt <= fe_cnt + 1;
    if (o_busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCK period; optionally pops the FIFO during the PUSH cycle that follows this rise.
  task automatic spi_bit(input logic b, input bit rd_in_push);
    logic [DATA_W-1:0] exp;
    sck = 0; mosi = b; wait_clk(4); sck = 1;
    if (rd_in_push) begin
      @(posedge clk); @(posedge clk); @(posedge clk); @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (o_empty !== 1'b0 || o_data !== exp) begin
        errors++;
        $display("FAIL pop_in_push: got empty=%b data=%h expected empty=0 data=%h", o_empty, o_data, exp);
      end
      rd = 1; @(negedge clk); rd = 0;
      wait_clk(2);
    end else begin
      wait_clk(4);
    end
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w, input int nbits, input bit rd_last);
    for (int i = 0; i < nbits; i++) spi_bit(w[DATA_W-1-i], rd_last && (i == nbits-1));
  endtask

  task automatic expect_word(input logic [DATA_W-1:0] w);
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
  endtask

  task automatic pop_check(input string name);
    logic [DATA_W-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got data=%h expected no pending word", name, o_data);
    end else begin
      exp = exp_q.pop_front();
      if (o_empty !== 1'b0 || o_data !== exp) begin
        errors++;
        $display("FAIL %s: got empty=%b data=%h expected empty=0 data=%h", name, o_empty, o_data, exp);
      end
    end
    rd = 1; @(negedge clk); rd = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; wait_clk(3);
    checks++;
    if ({o_empty, o_full, o_count, o_ovf, o_frame_err, o_busy} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0} || o_data !== '0) begin
      errors++;
      $display("FAIL reset: got empty=%b full=%b count=%0d ovf=%b fe=%b busy=%b data=%h expected 1 0 0 0 0 0 0",
               o_empty, o_full, o_count, o_ovf, o_frame_err, o_busy, o_data);
    end
    rst_n = 1; wait_clk(3);
  endtask

  task automatic test_single;
    cs = 0; wait_clk(4);
    expect_word(32'hA5C30F96);
    send_word(32'hA5C30F96, DATA_W, 0);
    sck = 0; cs = 1; wait_clk(4);
    checks++;
    if (o_count !== 3'd1 || o_empty !== 1'b0) begin
      errors++;
      $display("FAIL single_count: got count=%0d empty=%b expected count=1 empty=0", o_count, o_empty);
    end
    pop_check("single_data");
    checks++;
    if (o_count !== 3'd0 || o_empty !== 1'b1) begin
      errors++;
      $display("FAIL single_drain: got count=%0d empty=%b expected count=0 empty=1", o_count, o_empty);
    end
  endtask

  task automatic test_back_to_back;
    cs = 0; wait_clk(4);
    for (int k = 1; k <= 5; k++) begin
      expect_word(DATA_W'(k));
      send_word(DATA_W'(k), DATA_W, 0);
    end
    sck = 0; cs = 1; wait_clk(4);
    checks++;
    if (o_full !== 1'b1 || o_ovf !== 1'b1 || o_count !== 3'd4) begin
      errors++;
      $display("FAIL b2b_full: got full=%b ovf=%b count=%0d expected full=1 ovf=1 count=4", o_full, o_ovf, o_count);
    end
    for (int k = 0; k < DEPTH; k++) pop_check("b2b_pop");
    checks++;
    if (o_empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_empty: got empty=%b expected 1", o_empty);
    end
    ovf_clr = 1; wait_clk(1); ovf_clr = 0;
    checks++;
    if (o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: got ovf=%b expected 0", o_ovf);
    end
  endtask

  task automatic test_frame_err;
    int fe0;
    logic [AW:0] cnt0;
    fe0 = fe_cnt; cnt0 = o_count;
    cs = 0; wait_clk(4);
    send_word(32'hABC00000, 12, 0);
    sck = 0; wait_clk(2); cs = 1; wait_clk(8);
    checks++;
    if (fe_cnt - fe0 !== 1 || o_count !== cnt0) begin
      errors++;
      $display("FAIL frame_err: got pulses=%0d count=%0d expected pulses=1 count=%0d", fe_cnt - fe0, o_count, cnt0);
    end
    fe0 = fe_cnt;
    cs = 0; wait_clk(4);
    expect_word(32'hDEADBEEF);
    send_word(32'hDEADBEEF, DATA_W, 0);
    sck = 0; cs = 1; wait_clk(6);
    checks++;
    if (fe_cnt !== fe0) begin
      errors++;
      $display("FAIL clean_no_fe: got pulses=%0d expected 0", fe_cnt - fe0);
    end
    pop_check("after_err_data");
  endtask

  task automatic test_push_pop_full;
    cs = 0; wait_clk(4);
    for (int k = 0; k < DEPTH; k++) begin
      expect_word(32'h10 + DATA_W'(k));
      send_word(32'h10 + DATA_W'(k), DATA_W, 0);
    end
    exp_q.push_back(32'h77);
    send_word(32'h77, DATA_W, 1);
    sck = 0; cs = 1; wait_clk(4);
    checks++;
    if (o_count !== 3'd4 || o_ovf !== 1'b0 || o_full !== 1'b1) begin
      errors++;
      $display("FAIL full_pushpop: got count=%0d ovf=%b full=%b expected count=4 ovf=0 full=1", o_count, o_ovf, o_full);
    end
    for (int k = 0; k < DEPTH; k++) pop_check("full_pushpop_pop");
  endtask

  task automatic test_reset_mid;
    cs = 0; wait_clk(4);
    expect_word(32'hCAFEF00D);
    send_word(32'hCAFEF00D, DATA_W, 0);
    send_word(32'h0F0F0F0F, 20, 0);
    rst_n = 0; #1;
    checks++;
    if ({o_empty, o_full, o_count, o_ovf, o_frame_err, o_busy} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0} || o_data !== '0) begin
      errors++;
      $display("FAIL reset_mid: got empty=%b full=%b count=%0d ovf=%b fe=%b busy=%b data=%h expected 1 0 0 0 0 0 0",
               o_empty, o_full, o_count, o_ovf, o_frame_err, o_busy, o_data);
    end
    exp_q.delete();
    sck = 0; cs = 1; wait_clk(3); rst_n = 1; wait_clk(4);
    cs = 0; wait_clk(4);
    expect_word(32'h12345678);
    send_word(32'h12345678, DATA_W, 0);
    sck = 0; cs = 1; wait_clk(4);
    pop_check("after_reset_data");
  endtask

  task automatic test_idle_sck;
    int b0, fe0;
    b0 = busy_cnt; fe0 = fe_cnt;
    cs = 1;
    for (int k = 0; k < 20; k++) spi_bit(1'($urandom_range(0, 1)), 0);
    sck = 0; wait_clk(4);
    checks++;
    if (busy_cnt !== b0 || fe_cnt !== fe0 || o_count !== 3'd0 || o_empty !== 1'b1) begin
      errors++;
      $display("FAIL idle_sck: got busy_cycles=%0d fe=%0d count=%0d empty=%b expected 0 0 0 1",
               busy_cnt - b0, fe_cnt - fe0, o_count, o_empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_push_pop_full();
    test_reset_mid();
    test_idle_sck();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
